// File: rtl/ofifo_drain_ctrl.sv
// Output-FIFO drain controller: reads one row at a time, waits RD_LAT cycles, writes it to SRAM.
// Optional build macro OFIFO_DRAIN_RELU_EN clamps negative column words to zero on the way out.
module ofifo_drain_ctrl #(
  parameter int col    = 8,
  parameter int bw     = 16,
  parameter int AW     = 11,
  parameter int RD_LAT = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [6:0]          num_rows,
  input  logic [AW-1:0]       base_addr,
  input  logic                ofifo_valid,
  input  logic [col*bw-1:0]   ofifo_dout,
  output logic                ofifo_rd,
  output logic                sram_wen,
  output logic [AW-1:0]       sram_addr,
  output logic [col*bw-1:0]   sram_din,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DATA, WRITE, FINISH} state_t;

  localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

  state_t              state;
  logic [6:0]          num_q;
  logic [6:0]          row_cnt;
  logic [AW-1:0]       addr_q;
  logic [2:0]          lat_cnt;
  logic [col*bw-1:0]   row_p0;

  function automatic logic [col*bw-1:0] post_proc(input logic [col*bw-1:0] row);
    logic [col*bw-1:0] res;
`ifdef OFIFO_DRAIN_RELU_EN
    logic signed [bw-1:0] w;
`endif
    res = row;
`ifdef OFIFO_DRAIN_RELU_EN
    for (int c = 0; c < col; c++) begin
      w = row[c*bw +: bw];
      if (w < 0) res[c*bw +: bw] = '0;
    end
`endif
    return res;
  endfunction

  // Read strobe is issued in the ISSUE cycle itself so a row costs only RD_LAT+2 cycles.
  assign ofifo_rd = !reset && (state == ISSUE) && ofifo_valid;

  // Row capture: data lands RD_LAT cycles after the read strobe
  always_ff @(posedge clk) begin
    if (state == WAIT_DATA && lat_cnt == LAT_LAST) row_p0 <= ofifo_dout;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      sram_wen  <= 1'b0;
      sram_addr <= '0;
      sram_din  <= '0;
      num_q     <= '0;
      row_cnt   <= '0;
      addr_q    <= '0;
      lat_cnt   <= '0;
    end else begin
      done     <= 1'b0;
      sram_wen <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            num_q   <= num_rows;
            addr_q  <= base_addr;
            row_cnt <= '0;
            state   <= (num_rows == 7'd0) ? FINISH : ISSUE;
          end
        end
        ISSUE: begin
          if (ofifo_valid) begin
            lat_cnt <= '0;
            state   <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (lat_cnt == LAT_LAST) state <= WRITE;
          else                     lat_cnt <= lat_cnt + 3'd1;
        end
        // Write stage: address wraps modulo 2^AW without any flag
        WRITE: begin
          sram_wen  <= 1'b1;
          sram_addr <= addr_q;
          sram_din  <= post_proc(row_p0);
          addr_q    <= addr_q + AW'(1);
          row_cnt   <= row_cnt + 7'd1;
          state     <= (row_cnt + 7'd1 == num_q) ? FINISH : ISSUE;
        end
        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ofifo_drain_ctrl.sv
// Scoreboard bench for ofifo_drain_ctrl: directed drains, expected SRAM writes/done queued with their cycle.
module tb_ofifo_drain_ctrl;
  localparam int COL = 8, BW = 16, AW = 11, RD_LAT = 2, W = COL * BW;
  localparam logic [W-1:0] GARB = {COL{16'hBAD0}};
  localparam logic [W-1:0] R0 = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
  localparam logic [W-1:0] R1 = 128'h1111_2222_3333_4444_5555_6666_7777_0FFF;
  localparam logic [W-1:0] R2 = 128'h7FFF_0000_0100_0200_0300_0400_0500_0600;
  localparam logic [W-1:0] R6 = 128'hFFF0_0010_FFF0_0010_8000_7FFF_0000_FFFF;
`ifdef OFIFO_DRAIN_RELU_EN
  localparam logic [W-1:0] R6_EXP = 128'h0000_0010_0000_0010_0000_7FFF_0000_0000;
`else
  localparam logic [W-1:0] R6_EXP = 128'hFFF0_0010_FFF0_0010_8000_7FFF_0000_FFFF;
`endif

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, ofifo_valid = 1'b0;
  logic [6:0] num_rows = '0;
  logic [AW-1:0] base_addr = '0;
  logic [W-1:0] ofifo_dout = GARB;
  logic ofifo_rd, sram_wen, busy, done;
  logic [AW-1:0] sram_addr;
  logic [W-1:0] sram_din;

  ofifo_drain_ctrl #(.col(COL), .bw(BW), .AW(AW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .num_rows(num_rows), .base_addr(base_addr),
    .ofifo_valid(ofifo_valid), .ofifo_dout(ofifo_dout), .ofifo_rd(ofifo_rd),
    .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_din(sram_din), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { bit is_done; int cyc; logic [AW-1:0] addr; logic [W-1:0] din; } ev_t;
  typedef struct { int cyc; logic [W-1:0] data; } rd_t;
  ev_t exp_q[$];
  rd_t rd_q[$];
  logic [W-1:0] src_q[$];

  int cyc = 0, n_cmp = 0, n_err = 0, rd_count = 0;
  logic [AW-1:0] hold_addr = '0;
  logic [W-1:0] hold_din = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output-FIFO model: row appears on ofifo_dout exactly RD_LAT cycles after the read strobe
  always @(posedge clk) begin
    #1;
    if (rd_q.size() != 0 && rd_q[0].cyc + RD_LAT == cyc) begin
      ofifo_dout = rd_q[0].data;
      void'(rd_q.pop_front());
    end else begin
      ofifo_dout = GARB;
    end
  end

  task automatic check_evt(input bit is_done);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_%s: cyc=%0d addr=%h, required no event", is_done ? "done" : "write", cyc, sram_addr);
      return;
    end
    e = exp_q.pop_front();
    if (is_done) begin
      if (!e.is_done || e.cyc != cyc || busy !== 1'b0) begin
        n_err++;
        $display("FAIL done_event: got done at cyc=%0d busy=%b, required cyc=%0d is_done=%0d busy=0", cyc, busy, e.cyc, e.is_done);
      end
    end else begin
      if (e.is_done || e.cyc != cyc || sram_addr !== e.addr || sram_din !== e.din) begin
        n_err++;
        $display("FAIL sram_write: got cyc=%0d addr=%h din=%h, required cyc=%0d addr=%h din=%h done_ev=%0d",
                 cyc, sram_addr, sram_din, e.cyc, e.addr, e.din, e.is_done);
      end
      hold_addr = e.addr;
      hold_din  = e.din;
    end
  endtask

  // Monitor: records read strobes and checks every write/done against the scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (ofifo_rd) begin
        rd_count++;
        if (src_q.size() != 0) rd_q.push_back('{cyc, src_q.pop_front()});
        else                   rd_q.push_back('{cyc, GARB});
      end
      if (sram_wen) check_evt(1'b0);
      else begin
        n_cmp++;
        if (sram_addr !== hold_addr || sram_din !== hold_din) begin
          n_err++;
          $display("FAIL hold: got addr=%h din=%h, required addr=%h din=%h", sram_addr, sram_din, hold_addr, hold_din);
        end
      end
      if (done) check_evt(1'b1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic expect_wr(input int c, input logic [AW-1:0] a, input logic [W-1:0] d);
    exp_q.push_back('{1'b0, c, a, d});
  endtask

  task automatic expect_done(input int c);
    exp_q.push_back('{1'b1, c, '0, '0});
  endtask

  task automatic start_drain(input logic [6:0] n, input logic [AW-1:0] b, output int s);
    start = 1'b1; num_rows = n; base_addr = b; s = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int limit);
    int k = 0;
    while (exp_q.size() != 0 && k < limit) begin tick(); k++; end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_timeout: %0d events outstanding after %0d cycles, required 0", name, exp_q.size(), limit);
      exp_q.delete();
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, rd0;
    repeat (3) tick();
    chk("reset_rd", W'(ofifo_rd), '0);
    chk("reset_wen", W'(sram_wen), '0);
    chk("reset_busy", W'(busy), '0);
    chk("reset_done", W'(done), '0);
    chk("reset_addr", W'(sram_addr), '0);
    chk("reset_din", sram_din, '0);
    reset = 1'b0;
    tick();

    // Three rows, valid always high, plus an ignored start while busy
    ofifo_valid = 1'b1;
    src_q.push_back(R0); src_q.push_back(R1); src_q.push_back(R2);
    rd0 = rd_count;
    start_drain(7'd3, 11'h010, s);
    expect_wr(s + 5, 11'h010, R0);
    expect_wr(s + 9, 11'h011, R1);
    expect_wr(s + 13, 11'h012, R2);
    expect_done(s + 14);
    chk("busy_after_start", W'(busy), W'(1));
    tick(); tick();
    start = 1'b1; num_rows = 7'd0; base_addr = 11'h555;
    tick();
    start = 1'b0;
    wait_drain("three_rows", 40);
    chk("three_rows_rd_count", W'(rd_count - rd0), W'(3));
    chk("three_rows_busy_end", W'(busy), '0);

    // Zero-row request
    rd0 = rd_count;
    start_drain(7'd0, 11'h055, s);
    expect_done(s + 2);
    wait_drain("zero_rows", 10);
    chk("zero_rows_rd_count", W'(rd_count - rd0), '0);

    // Stall with valid low for ten cycles
    ofifo_valid = 1'b0;
    src_q.push_back(R1);
    rd0 = rd_count;
    start_drain(7'd1, 11'h100, s);
    for (int i = 0; i < 10; i++) begin
      chk("stall_busy", W'(busy), W'(1));
      tick();
    end
    chk("stall_no_rd", W'(rd_count - rd0), '0);
    ofifo_valid = 1'b1;
    expect_wr(s + 15, 11'h100, R1);
    expect_done(s + 16);
    wait_drain("stall", 30);

    // Address wrap at 2^AW
    src_q.push_back(R2); src_q.push_back(R0);
    start_drain(7'd2, 11'h7FF, s);
    expect_wr(s + 5, 11'h7FF, R2);
    expect_wr(s + 9, 11'h000, R0);
    expect_done(s + 10);
    wait_drain("wrap", 30);

    // Reset after the first write of a four-row drain
    src_q.push_back(R0); src_q.push_back(R1); src_q.push_back(R2); src_q.push_back(R1);
    start_drain(7'd4, 11'h020, s);
    expect_wr(s + 5, 11'h020, R0);
    while (cyc < s + 6) tick();
    reset = 1'b1;
    hold_addr = '0; hold_din = '0;
    rd_q.delete(); src_q.delete();
    tick();
    reset = 1'b0;
    chk("abort_rd", W'(ofifo_rd), '0);
    chk("abort_wen", W'(sram_wen), '0);
    chk("abort_busy", W'(busy), '0);
    chk("abort_done", W'(done), '0);
    chk("abort_addr", W'(sram_addr), '0);
    chk("abort_din", sram_din, '0);
    chk("abort_first_write_seen", W'(exp_q.size()), '0);
    repeat (20) tick();
    src_q.push_back(R2);
    start_drain(7'd1, 11'h030, s);
    expect_wr(s + 5, 11'h030, R2);
    expect_done(s + 6);
    wait_drain("after_abort", 20);

    // Negative / positive column words
    src_q.push_back(R6);
    start_drain(7'd1, 11'h3A5, s);
    expect_wr(s + 5, 11'h3A5, R6_EXP);
    expect_done(s + 6);
    wait_drain("relu_row", 20);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
